pdc_write_queue: RTL and testbench

- Write-side feeder for the 2048-entry predictor RAM, which has one write port and three read ports.
- Accepts bursty table updates from the retire/training logic and buffers them in a small FIFO.
- Coalesces updates that target the same address, then drains at most one write per cycle into the RAM's single write port (write_addr/write_data/write_wen).
- Sits directly upstream of the RAM write port.

---
 rtl/pdc_write_queue_if.sv | 41 ++++
 rtl/pdc_write_queue.sv | 75 +++++++
 tb/tb_pdc_write_queue.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pdc_write_queue_if.sv
// pdc_write_queue_if: update, drain, flush and occupancy bundle for pdc_write_queue.
// Defining PDC_WQ_FORWARD_EN adds the three forwarding lookup ports.
interface pdc_write_queue_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 11
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_data;
    logic              upd_ready;
    logic              drain_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              write_wen;
    logic              flush;
    logic [CW-1:0]     occupancy;
`ifdef PDC_WQ_FORWARD_EN
    logic [2:0][ADDR_W-1:0] fwd_addr;
    logic [2:0]             fwd_hit;
    logic [2:0][DATA_W-1:0] fwd_data;
    modport master (
        output upd_valid, upd_addr, upd_data, drain_en, flush, fwd_addr,
        input  upd_ready, write_addr, write_data, write_wen, occupancy, fwd_hit, fwd_data
    );
    modport slave (
        input  upd_valid, upd_addr, upd_data, drain_en, flush, fwd_addr,
        output upd_ready, write_addr, write_data, write_wen, occupancy, fwd_hit, fwd_data
    );
`else
    modport master (
        output upd_valid, upd_addr, upd_data, drain_en, flush,
        input  upd_ready, write_addr, write_data, write_wen, occupancy
    );
    modport slave (
        input  upd_valid, upd_addr, upd_data, drain_en, flush,
        output upd_ready, write_addr, write_data, write_wen, occupancy
    );
`endif
endinterface

// File: rtl/pdc_write_queue.sv
// pdc_write_queue: coalescing write FIFO feeding the predictor RAM's single write port.
// Optional PDC_WQ_FORWARD_EN adds a 3-port combinational forwarding lookup of pending writes.
module pdc_write_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 11
) (
    input logic               clk,
    input logic               rst,
    pdc_write_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0]     head, tail, hit_idx;
    logic [CW-1:0]     count;
    logic [DEPTH-1:0]  valid, match;
    logic [ADDR_W-1:0] addr [DEPTH];
    logic [DATA_W-1:0] data [DEPTH];
    logic              pop, push, append, coalesce;
    assign bus.upd_ready  = count != CW'(DEPTH);
    assign pop            = (count != '0) && bus.drain_en;
    assign bus.write_wen  = pop;
    assign bus.write_addr = (count != '0) ? addr[head] : '0;
    assign bus.write_data = (count != '0) ? data[head] : '0;
    assign bus.occupancy  = count;
    assign push           = bus.upd_valid && bus.upd_ready;
    // A head slot leaving this cycle cannot absorb new data; the update queues behind it
    always_comb begin
        match   = '0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (addr[i] == bus.upd_addr) && !(pop && (PW'(i) == head));
            if (match[i]) hit_idx = PW'(i);
        end
    end
    assign coalesce = push && (|match);
    assign append   = push && !(|match);
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (append) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            count <= count + CW'(append) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (append) begin
            addr[tail] <= bus.upd_addr;
            data[tail] <= bus.upd_data;
        end
        if (coalesce) data[hit_idx] <= bus.upd_data;
    end
`ifdef PDC_WQ_FORWARD_EN
    always_comb begin
        bus.fwd_hit  = '0;
        bus.fwd_data = '0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < DEPTH; i++)
                if (valid[i] && (addr[i] == bus.fwd_addr[k])) begin
                    bus.fwd_hit[k]  = 1'b1;
                    bus.fwd_data[k] = data[i];
                end
    end
`endif
endmodule

// File: tb/tb_pdc_write_queue.sv
// tb_pdc_write_queue: directed stimulus with a write scoreboard checked by an independent RAM-port monitor.
module tb_pdc_write_queue;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 4;
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    wr_t  exp_q[$];
    int   checks = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    pdc_write_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus();
    pdc_write_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    // every RAM write (outside reset) must match the next expected write in order
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.write_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got addr=%h data=%h, none expected", bus.write_addr, bus.write_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.write_addr !== e.a || bus.write_data !== e.d) begin
                    fails++;
                    $display("FAIL ram_write got addr=%h data=%h expected addr=%h data=%h",
                             bus.write_addr, bus.write_data, e.a, e.d);
                end
            end
        end
    end
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask
    task automatic set(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic de, input logic fl);
        bus.upd_valid = v;
        bus.upd_addr  = a;
        bus.upd_data  = d;
        bus.drain_en  = de;
        bus.flush     = fl;
    endtask
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        set(1'b1, a, d, 1'b0, 1'b0);
        cyc();
    endtask
    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask
    task automatic drain(input int n);
        set(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (n) cyc();
        set(1'b0, '0, '0, 1'b0, 1'b0);
    endtask
    initial begin
        set(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef PDC_WQ_FORWARD_EN
        bus.fwd_addr = '0;
`endif
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("reset_occupancy", 64'(bus.occupancy), 0);
        check("reset_ready", 64'(bus.upd_ready), 1);
        check("reset_wen", 64'(bus.write_wen), 0);
        check("reset_waddr", 64'(bus.write_addr), 0);
        check("reset_wdata", bus.write_data, 0);
        cyc();
        // single push, stalled, then released
        expect_wr(11'h005, 64'hAA);
        push(11'h005, 64'hAA);
        set(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("single_occ", 64'(bus.occupancy), 1);
        check("single_stalled_wen", 64'(bus.write_wen), 0);
        cyc();
        set(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check("single_wen", 64'(bus.write_wen), 1);
        cyc();
        @(negedge clk);
        check("single_occ_after", 64'(bus.occupancy), 0);
        check("empty_wen_with_drain", 64'(bus.write_wen), 0);
        cyc();
        // fill to full, hold a fifth, drain one
        for (int i = 0; i < 5; i++) expect_wr(ADDR_W'(16 + i), 64'(i + 1));
        for (int i = 0; i < 4; i++) push(ADDR_W'(16 + i), 64'(i + 1));
        set(1'b1, 11'h014, 64'd5, 1'b0, 1'b0);
        @(negedge clk);
        check("full_ready", 64'(bus.upd_ready), 0);
        check("full_occ", 64'(bus.occupancy), 4);
        cyc();
        @(negedge clk);
        check("held_occ", 64'(bus.occupancy), 4);
        cyc();
        set(1'b1, 11'h014, 64'd5, 1'b1, 1'b0);
        @(negedge clk);
        check("full_pop_no_credit", 64'(bus.upd_ready), 0);
        cyc();
        set(1'b1, 11'h014, 64'd5, 1'b0, 1'b0);
        @(negedge clk);
        check("ready_after_pop", 64'(bus.upd_ready), 1);
        check("occ_after_pop", 64'(bus.occupancy), 3);
        cyc();
        set(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("refill_occ", 64'(bus.occupancy), 4);
        drain(4);
        @(negedge clk);
        check("fill_drained_occ", 64'(bus.occupancy), 0);
        cyc();
        // coalescing keeps the original slot position
        expect_wr(11'h020, 64'h3);
        expect_wr(11'h021, 64'h2);
        push(11'h020, 64'h1);
        push(11'h021, 64'h2);
        push(11'h020, 64'h3);
        set(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("coalesce_occ", 64'(bus.occupancy), 2);
        drain(3);
        @(negedge clk);
        check("coalesce_drained", 64'(bus.occupancy), 0);
        cyc();
        // update to the head being popped must append behind it
        expect_wr(11'h030, 64'h4);
        expect_wr(11'h030, 64'h5);
        push(11'h030, 64'h4);
        set(1'b1, 11'h030, 64'h5, 1'b1, 1'b0);
        @(negedge clk);
        check("headpop_wen", 64'(bus.write_wen), 1);
        cyc();
        set(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check("headpop_occ", 64'(bus.occupancy), 1);
        check("headpop_second_wen", 64'(bus.write_wen), 1);
        cyc();
        @(negedge clk);
        check("headpop_done", 64'(bus.occupancy), 0);
        set(1'b0, '0, '0, 1'b0, 1'b0);
        cyc();
        // flush: in-flight head write still issues, the rest and the new update vanish
        expect_wr(11'h050, 64'h1);
        push(11'h050, 64'h1);
        push(11'h051, 64'h2);
        push(11'h052, 64'h3);
        set(1'b1, 11'h053, 64'h9, 1'b1, 1'b1);
        @(negedge clk);
        check("flush_pre_occ", 64'(bus.occupancy), 3);
        check("flush_cycle_wen", 64'(bus.write_wen), 1);
        cyc();
        set(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check("flush_occ", 64'(bus.occupancy), 0);
        check("flush_wen", 64'(bus.write_wen), 0);
        check("flush_ready", 64'(bus.upd_ready), 1);
        cyc();
        // same with reset
        push(11'h060, 64'h1);
        push(11'h061, 64'h2);
        push(11'h062, 64'h3);
        set(1'b1, 11'h063, 64'h9, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pre_occ", 64'(bus.occupancy), 3);
        cyc();
        rst = 1'b0;
        set(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_occ", 64'(bus.occupancy), 0);
        check("rst_wen", 64'(bus.write_wen), 0);
        set(1'b0, '0, '0, 1'b0, 1'b0);
        cyc();
`ifdef PDC_WQ_FORWARD_EN
        expect_wr(11'h040, 64'h7);
        push(11'h040, 64'h7);
        set(1'b0, '0, '0, 1'b0, 1'b0);
        bus.fwd_addr[0] = 11'h040;
        bus.fwd_addr[1] = 11'h041;
        bus.fwd_addr[2] = 11'h040;
        @(negedge clk);
        check("fwd_hit", 64'(bus.fwd_hit), 64'b101);
        check("fwd_data0", bus.fwd_data[0], 64'h7);
        check("fwd_data2", bus.fwd_data[2], 64'h7);
        cyc();
        set(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check("fwd_hit_during_write", 64'(bus.fwd_hit), 64'b101);
        cyc();
        set(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("fwd_hit_after", 64'(bus.fwd_hit), 0);
        cyc();
`endif
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
